store_buffer: RTL

- Data-memory-side stage directly downstream of the pipelined core's memory stage.
- Queues core stores (MemWrite/ALUResult/WriteData) in a FIFO and drains them to the data RAM over a req/ack write handshake, so slow RAM writes do not stall the core.
- Services loads: forwards data from the youngest matching buffered store, otherwise returns RAM read data.

---
 rtl/store_buffer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : store_buffer
//  Purpose  : FIFO of core stores drained to data RAM over a req/ack write
//             handshake, with youngest-match load forwarding.
//             Optional macro STORE_COALESCE_EN merges a store into the
//             youngest entry when the word addresses match.
//  Revision : 1.0  initial release
// ============================================================================
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     MemWrite,
  input  logic                     MemRead,
  input  logic [AW-1:0]            ALUResult,
  input  logic [DW-1:0]            WriteData,
  output logic [DW-1:0]            ReadData,
  output logic                     Stall,
  output logic                     mem_we,
  output logic [AW-1:0]            mem_waddr,
  output logic [DW-1:0]            mem_wdata,
  input  logic                     mem_wack,
  output logic [AW-1:0]            mem_raddr,
  input  logic [DW-1:0]            mem_rdata,
  output logic                     sb_empty,
  output logic [$clog2(DEPTH):0]   sb_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [AW-1:0] addr_d [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [AW-1:0] word_addr;
  logic          full;
  logic          coalesce;
  logic          enq;
  logic          deq;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic [PW-1:0] idx;

  assign word_addr = ALUResult & ~AW'(3);
  assign full      = (count_q == CW'(DEPTH));

`ifdef STORE_COALESCE_EN
  logic [PW-1:0] tail_m1;
  assign tail_m1  = tail_q - PW'(1);
  // count>=2 guarantees tail-1 is never the head, which may be mid-handshake
  assign coalesce = MemWrite && (count_q >= CW'(2)) && valid_q[tail_m1] &&
                    (addr_q[tail_m1] == word_addr);
`else
  assign coalesce = 1'b0;
`endif

  assign enq   = MemWrite && !full && !coalesce;
  assign Stall = MemWrite && full && !coalesce;

  assign mem_we    = (count_q != '0);
  assign mem_waddr = addr_q[head_q];
  assign mem_wdata = data_q[head_q];
  assign deq       = mem_we && mem_wack;

  assign sb_empty  = (count_q == '0);
  assign sb_count  = count_q;
  assign mem_raddr = word_addr;

  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (deq) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PW'(1);
    end

    if (enq) begin
      addr_d[tail_q]  = word_addr;
      data_d[tail_q]  = WriteData;
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PW'(1);
    end

`ifdef STORE_COALESCE_EN
    if (coalesce) begin
      data_d[tail_m1] = WriteData;
    end
`endif

    case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Scan oldest to youngest so the last hit is the youngest matching store.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (valid_q[idx] && (addr_q[idx] == word_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

  assign ReadData = (MemRead && fwd_hit) ? fwd_data : mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire
